// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by both the transmit and the receive side.
//   uart_state_t : frame sequencer states (IDLE / START / DATA / STOP)
//   BYTE_W       : width of one UART data byte
//   calc_div()   : clock cycles per bit, truncated integer division
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Cycles per bit period; the fractional part is dropped
    // (27 MHz / 115200 -> 234).
    function automatic int calc_div(input int clk_freq_mhz, input int baud_rate);
        return (clk_freq_mhz * 1000000) / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Byte queue in front of the UART transmitter.
// Ports:
//   clk        in   system clock
//   reset      in   synchronous active-high reset (empties the queue)
//   push       in   write push_data (ignored while full)
//   push_data  in   byte to enqueue
//   pop        in   drop the head entry (ignored while empty)
//   pop_data   out  current head entry, valid while !empty
//   full       out  DEPTH entries held
//   empty      out  no entries held
//   count      out  number of entries held, 0..DEPTH
// DEPTH must be a power of two >= 2 so the pointers wrap for free.
// ---------------------------------------------------------------------------
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [BYTE_W-1:0]        push_data,
    input  logic                     pop,
    output logic [BYTE_W-1:0]        pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            // Push and pop together leave the occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; entries are only
    // read after being written, and the reset pointers mark them all invalid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_byte_driver.sv
// ---------------------------------------------------------------------------
// uart_byte_driver
// Queued 8N1 UART transmitter: bytes handed over on a valid/ready port are
// buffered and shifted out LSB first, back-to-back frames without idle gap.
// Ports:
//   clk       in   system clock, all logic on posedge
//   reset     in   synchronous active-high reset; aborts frame, flushes queue
//   in_valid  in   byte offered on in_byte
//   in_byte   in   byte to transmit
//   in_ready  out  queue can accept a byte this cycle (queue not full)
//   tx_line   out  registered serial line, idle high
//   busy      out  queue non-empty or a frame in progress
// ---------------------------------------------------------------------------
module uart_byte_driver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_MHZ = 27,
    parameter int BAUD_RATE    = 115200,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_byte,
    output logic              in_ready,
    output logic              tx_line,
    output logic              busy
);

    localparam int DIV   = calc_div(CLK_FREQ_MHZ, BAUD_RATE);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    uart_state_t       state, state_next;
    logic [CNT_W-1:0]  baud_cnt, baud_cnt_next;
    logic [2:0]        bit_idx, bit_idx_next;
    logic [BYTE_W-1:0] shift, shift_next;
    logic              tx_next;
    logic              bit_end;

    logic              fifo_push;
    logic              fifo_pop;
    logic [BYTE_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && in_ready;
    assign busy      = (state != IDLE) || (fifo_count != '0);
    assign bit_end   = (baud_cnt == CNT_MAX);

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (in_byte),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx_line  <= 1'b1;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_cnt_next;
            bit_idx  <= bit_idx_next;
            shift    <= shift_next;
            tx_line  <= tx_next;
        end
    end

    // tx_next is a function of the current state only; registering it delays
    // every bit boundary by one cycle, so each level still lasts DIV cycles.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned and no latch is inferred.
        state_next    = state;
        baud_cnt_next = (state == IDLE || bit_end) ? '0 : baud_cnt + CNT_W'(1);
        bit_idx_next  = bit_idx;
        shift_next    = shift;
        tx_next       = 1'b1;
        fifo_pop      = 1'b0;

        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_next = fifo_head;
                    state_next = START;
                end
            end
            START: begin
                tx_next = 1'b0;
                if (bit_end) begin
                    bit_idx_next = '0;
                    state_next   = DATA;
                end
            end
            DATA: begin
                tx_next = shift[0];
                if (bit_end) begin
                    shift_next = shift >> 1;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                // Chain straight into the next start bit when more bytes wait.
                if (bit_end) begin
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        shift_next = fifo_head;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: doc/uart_byte_driver.md
UART_BYTE_DRIVER -- requirements
Module: uart_byte_driver

Interface
REQ-001 SHALL have parameter CLK_FREQ_MHZ, default 27, system clock frequency in MHz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, line rate in bits/s.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, byte queue depth (power of two, >=2).
REQ-004 SHALL use one clock, `clk`; reset is synchronous and active-high, named `reset`.
REQ-005 clk  input  1  system clock, all logic on posedge.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 in_valid  input  1  byte offered on in_byte.
REQ-008 in_byte  input  8  byte to transmit.
REQ-009 in_ready  output  1  queue can accept a byte this cycle.
REQ-010 tx_line  output  1  serial line, idle high; drives the SoC UART_RX.
REQ-011 busy  output  1  queue non-empty or a frame in progress.

Function
REQ-012 Bit period SHALL be DIV = (CLK_FREQ_MHZ*1000000)/BAUD_RATE, integer truncation (27 MHz / 115200 -> 234 cycles).
REQ-013 Frame SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1): 10*DIV cycles total.
REQ-014 Byte SHALL be accepted on posedge when in_valid && in_ready; in_ready = queue not full.
REQ-015 When the queue is full, in_valid SHALL be ignored; no byte is overwritten or dropped silently.
REQ-016 Simultaneous push and pop on a full queue SHALL be allowed only as a pop (in_ready is low); on a non-full non-empty queue both SHALL take effect and the count is unchanged.
REQ-017 FSM states: IDLE, START, DATA, STOP.
REQ-018 IDLE: tx_line=1; if queue non-empty, pop head into shift register, go START next cycle.
REQ-019 START: tx_line=0 for DIV cycles, then DATA with bit index 0.
REQ-020 DATA: tx_line=shift[0] for DIV cycles per bit; shift right; after bit index 7 go STOP.
REQ-021 STOP: tx_line=1 for DIV cycles; then if queue non-empty, pop and go directly to START (no idle gap), else IDLE.
REQ-022 Latency: a byte pushed into an empty queue while IDLE SHALL drive the start bit on tx_line 2 cycles after the accepting edge.
REQ-023 Baud counter SHALL count 0..DIV-1 and wrap; width $clog2(DIV); bit index 3 bits.
REQ-024 Queue pointers SHALL wrap modulo FIFO_DEPTH; count width $clog2(FIFO_DEPTH)+1.
REQ-025 busy SHALL be 0 only in IDLE with an empty queue.
REQ-026 tx_line SHALL be registered (no combinational glitch).

Reset
REQ-027 On reset: FSM=IDLE, tx_line=1, queue empty, in_ready=1, busy=0, counters=0.
REQ-028 Reset mid-frame SHALL abort the frame and flush the queue; tx_line returns high on the next edge.
REQ-029 Reset SHALL take precedence over a simultaneous push.

Structure
REQ-030 Shared package uart_pkg SHALL hold the state enum (IDLE/START/DATA/STOP) and the divisor-computation function, reused by receive-side logic.
REQ-031 Byte queue SHALL be a sub-module uart_tx_fifo (parameter DEPTH, width 8, push/pop/full/empty/count).
REQ-032 Total RTL 120-400 lines; no vendor primitives.

Verification
REQ-033 Push 0x55 from idle -> tx_line low at edge+2, then bits 1,0,1,0,1,0,1,0, stop high; frame 2340 cycles; busy falls after.
REQ-034 Push 0x00 then 0xFF back-to-back -> frames contiguous (stop of first followed immediately by start of second), total 4680 cycles.
REQ-035 Hold in_valid for 6 bytes 0x01..0x06 -> in_ready drops after 5 accepted (1 shifting + 4 queued); 0x06 accepted once a slot frees; all six transmitted in order.
REQ-036 Loopback tx_line into uart_baud_monitor (27 MHz, 115200, OVERSAMPLE 16), send "Hi\n" -> monitor out_byte 0x48, 0x69, 0x0A in order.
REQ-037 Assert reset at cycle 1000 of a frame with 2 bytes queued -> tx_line=1 next edge, in_ready=1, busy=0, no further frames.
REQ-038 Push 0xA5 while on the stop bit of a previous frame -> 0xA5 starts with no idle gap.
